usr_burst_shifter: RTL and testbench

Parametrised universal shift register with serial ports, arithmetic and rotate modes, and a multi-step burst engine. It executes an N-step shift or rotate under a START/BUSY/DONE handshake. It is the next generation of the team's 4-bit universal shift register and serves as the shift/rotate datapath stage for serial links and bit-manipulation blocks.

---
 rtl/usr_burst_shifter.sv | 137 +++++++++++++
 tb/tb_usr_burst_shifter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_burst_shifter.sv
// Universal shift register with serial ports and an N-step burst engine.
// Define USR_ROTATE_EN to enable the rotate modes (100/101).
module usr_burst_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] DATAIN,
  input  logic             SIN_R,
  input  logic             SIN_L,
  input  logic             START,
  input  logic [CNT_W-1:0] COUNT,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             SOUT_R,
  output logic             SOUT_L,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] step_f(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] d,
    input logic             sr,
    input logic             sl,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] r;
    r = d;
    case (m)
      M_HOLD: r = d;
      M_SHR:  r = {sr, d[WIDTH-1:1]};
      M_SHL:  r = {d[WIDTH-2:0], sl};
      M_LOAD: r = din;
`ifdef USR_ROTATE_EN
      M_ROR:  r = {d[0], d[WIDTH-1:1]};
      M_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
`else
      M_ROR:  r = d;
      M_ROL:  r = d;
`endif
      M_ASR:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      M_CLR:  r = '0;
      default: r = d;
    endcase
    return r;
  endfunction

  // Only modes whose repeated application is meaningful get a RUN phase.
  function automatic logic burst_f(input logic [2:0] m);
    logic b;
    b = 1'b0;
    case (m)
      M_SHR, M_SHL, M_ASR: b = 1'b1;
`ifdef USR_ROTATE_EN
      M_ROR, M_ROL:        b = 1'b1;
`endif
      default:             b = 1'b0;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START && burst_f(MODE) && (COUNT != '0)) begin
          mode_d  = MODE;
          rem_d   = COUNT;
          state_d = RUN;
        end else begin
          data_d = step_f(MODE, data_q, SIN_R, SIN_L, DATAIN);
          done_d = START;
        end
      end
      RUN: begin
        data_d = step_f(mode_q, data_q, SIN_R, SIN_L, DATAIN);
        rem_d  = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= M_HOLD;
      rem_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign DATAOUT = data_q;
  assign SOUT_R  = data_q[0];
  assign SOUT_L  = data_q[WIDTH-1];
  assign BUSY    = (state_q == RUN);
  assign DONE    = done_q;

endmodule

// File: tb/tb_usr_burst_shifter.sv
// Directed self-checking bench for usr_burst_shifter (WIDTH=8, CNT_W=4).
// Expectations follow the build: rotate checks differ with USR_ROTATE_EN.
module tb_usr_burst_shifter;

  logic       clock;
  logic       reset;
  logic [2:0] MODE;
  logic [7:0] DATAIN;
  logic       SIN_R;
  logic       SIN_L;
  logic       START;
  logic [3:0] COUNT;
  logic [7:0] DATAOUT;
  logic       SOUT_R;
  logic       SOUT_L;
  logic       BUSY;
  logic       DONE;

  int total = 0;
  int bad = 0;

  usr_burst_shifter #(.WIDTH(8), .CNT_W(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .MODE   (MODE),
    .DATAIN (DATAIN),
    .SIN_R  (SIN_R),
    .SIN_L  (SIN_L),
    .START  (START),
    .COUNT  (COUNT),
    .DATAOUT(DATAOUT),
    .SOUT_R (SOUT_R),
    .SOUT_L (SOUT_L),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] d,
                     input logic b, input logic dn);
    total++;
    if (DATAOUT !== d || BUSY !== b || DONE !== dn) begin
      bad++;
      $display("FAIL %s: got data=%h busy=%b done=%b exp data=%h busy=%b done=%b",
               nm, DATAOUT, BUSY, DONE, d, b, dn);
    end
  endtask

  task automatic load(input logic [7:0] v);
    START = 1'b0;
    MODE = 3'b011;
    DATAIN = v;
    tick();
    MODE = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    MODE = 3'b011;
    DATAIN = 8'hFF;
    SIN_R = 1'b0;
    SIN_L = 1'b0;
    START = 1'b0;
    COUNT = 4'd0;
    #12;
    total++;
    if (DATAOUT !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got data=%h busy=%b done=%b exp 00 0 0",
               DATAOUT, BUSY, DONE);
    end
    @(negedge clock);
    reset = 1'b1;
    MODE = 3'b000;
    tick();
    chk("reset_hold", 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_single_step();
    load(8'h81);
    chk("ss_load", 8'h81, 1'b0, 1'b0);
    MODE = 3'b001;
    SIN_R = 1'b1;
    tick();
    chk("ss_shr", 8'hC0, 1'b0, 1'b0);
    MODE = 3'b110;
    SIN_R = 1'b0;
    tick();
    chk("ss_asr", 8'hE0, 1'b0, 1'b0);
    MODE = 3'b010;
    SIN_L = 1'b0;
    tick();
    chk("ss_shl", 8'hC0, 1'b0, 1'b0);
    total++;
    if (SOUT_L !== 1'b1 || SOUT_R !== 1'b0) begin
      bad++;
      $display("FAIL ss_sout: got sl=%b sr=%b exp sl=1 sr=0", SOUT_L, SOUT_R);
    end
    MODE = 3'b000;
    tick();
    chk("ss_hold", 8'hC0, 1'b0, 1'b0);
    MODE = 3'b111;
    tick();
    chk("ss_clear", 8'h00, 1'b0, 1'b0);
    MODE = 3'b000;
  endtask

  task automatic test_rotate();
    load(8'h96);
`ifdef USR_ROTATE_EN
    MODE = 3'b101;
    START = 1'b1;
    COUNT = 4'd3;
    tick();
    chk("rot_e0", 8'h96, 1'b1, 1'b0);
    MODE = 3'b011;
    DATAIN = 8'hFF;
    tick();
    chk("rot_e1", 8'h2D, 1'b1, 1'b0);
    START = 1'b0;
    MODE = 3'b111;
    tick();
    chk("rot_e2", 8'h5A, 1'b1, 1'b0);
    START = 1'b1;
    MODE = 3'b001;
    tick();
    chk("rot_e3", 8'hB4, 1'b0, 1'b1);
    START = 1'b0;
    MODE = 3'b000;
    tick();
    chk("rot_after", 8'hB4, 1'b0, 1'b0);
    MODE = 3'b100;
    tick();
    chk("rot_ss_ror", 8'h5A, 1'b0, 1'b0);
    MODE = 3'b000;
`else
    MODE = 3'b100;
    tick();
    chk("norot_ss_hold", 8'h96, 1'b0, 1'b0);
    START = 1'b1;
    COUNT = 4'd4;
    tick();
    chk("norot_start", 8'h96, 1'b0, 1'b1);
    START = 1'b0;
    MODE = 3'b000;
    tick();
    chk("norot_after", 8'h96, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_burst_serial();
    logic [7:0] bits;
    bits = 8'b0100_1101;
    load(8'h00);
    MODE = 3'b010;
    START = 1'b1;
    COUNT = 4'd8;
    tick();
    chk("ser_e0", 8'h00, 1'b1, 1'b0);
    START = 1'b0;
    MODE = 3'b011;
    for (int i = 0; i < 8; i++) begin
      SIN_L = bits[i];
      tick();
      total++;
      if (i < 7 && (BUSY !== 1'b1 || DONE !== 1'b0)) begin
        bad++;
        $display("FAIL ser_busy[%0d]: got busy=%b done=%b exp 1 0", i, BUSY, DONE);
      end else if (i == 7 && (BUSY !== 1'b0 || DONE !== 1'b1)) begin
        bad++;
        $display("FAIL ser_end: got busy=%b done=%b exp 0 1", BUSY, DONE);
      end
    end
    chk("ser_result", 8'hB2, 1'b0, 1'b1);
    SIN_L = 1'b0;
  endtask

  task automatic test_back_to_back();
    MODE = 3'b110;
    START = 1'b1;
    COUNT = 4'd2;
    tick();
    chk("b2b_e0", 8'hB2, 1'b1, 1'b0);
    START = 1'b0;
    MODE = 3'b000;
    tick();
    chk("b2b_e1", 8'hD9, 1'b1, 1'b0);
    tick();
    chk("b2b_e2", 8'hEC, 1'b0, 1'b1);
    tick();
    chk("b2b_idle", 8'hEC, 1'b0, 1'b0);
  endtask

  task automatic test_degenerate();
    load(8'hB2);
    MODE = 3'b001;
    SIN_R = 1'b0;
    START = 1'b1;
    COUNT = 4'd0;
    tick();
    chk("deg_cnt0", 8'h59, 1'b0, 1'b1);
    START = 1'b0;
    MODE = 3'b000;
    tick();
    chk("deg_cnt0_after", 8'h59, 1'b0, 1'b0);
    MODE = 3'b011;
    DATAIN = 8'h3C;
    START = 1'b1;
    COUNT = 4'd5;
    tick();
    chk("deg_load", 8'h3C, 1'b0, 1'b1);
    START = 1'b0;
    MODE = 3'b000;
    tick();
    chk("deg_load_after", 8'h3C, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    logic seen_done;
    load(8'hA5);
    MODE = 3'b110;
    START = 1'b1;
    COUNT = 4'd5;
    tick();
    START = 1'b0;
    MODE = 3'b000;
    tick();
    tick();
    chk("rmb_pre", 8'hE9, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("rmb_async", 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (DONE === 1'b1 || BUSY === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("FAIL rmb_no_done: got busy/done activity=%b exp 0", seen_done);
    end
    chk("rmb_final", 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_rotate();
    test_burst_serial();
    test_back_to_back();
    test_degenerate();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
